// File: rtl/fft16_pkg.sv
// Shared constants and types for the 16-point FFT datapath.
// Holds the coarse twiddle table (scaled by TW_SCALE, so 4 means 1.0).
package fft16_pkg;

  localparam int DW = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  localparam int TW_SCALE = 4;

  localparam logic signed [3:0] TW_RE [8] = '{
    4'sd4, 4'sd4, 4'sd2, 4'sd1, 4'sd0, -4'sd1, -4'sd2, -4'sd4
  };

  localparam logic signed [3:0] TW_IM [8] = '{
    4'sd0, -4'sd1, -4'sd2, -4'sd4, -4'sd4, -4'sd4, -4'sd2, -4'sd1
  };

endpackage

// File: rtl/fft16_cmul.sv
// Combinational complex multiply of a difference term by a table twiddle,
// followed by a signed divide-by-scale (truncating toward zero).
// Build option FFT_BF_SAT_EN: clamp results to the DW-bit signed range
// instead of wrapping.
module fft16_cmul #(
  parameter int DW = 16
) (
  input  logic signed [DW:0]   tr,
  input  logic signed [DW:0]   ti,
  input  logic        [2:0]    k,
  output logic signed [DW-1:0] dr,
  output logic signed [DW-1:0] di
);
  import fft16_pkg::*;

  localparam int PW = DW + 6;
  localparam logic signed [PW-1:0] SCALE = PW'(TW_SCALE);
  localparam logic signed [PW-1:0] QMAX  = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN  = -QMAX - PW'(1);

  logic signed [PW-1:0] wrx, wix, trx, tix, pr, pi, qr, qi;

  // Full-width products, then true signed division so negatives round toward zero
  always_comb begin
    wrx = PW'(TW_RE[k]);
    wix = PW'(TW_IM[k]);
    trx = PW'(tr);
    tix = PW'(ti);
    pr  = wrx * trx - wix * tix;
    pi  = wrx * tix + wix * trx;
    qr  = pr / SCALE;
    qi  = pi / SCALE;
  end

  // Reduce the quotients to DW bits, clamping or wrapping depending on the build
  always_comb begin
`ifdef FFT_BF_SAT_EN
    if (qr > QMAX)      dr = DW'(QMAX);
    else if (qr < QMIN) dr = DW'(QMIN);
    else                dr = DW'(qr);
    if (qi > QMAX)      di = DW'(QMAX);
    else if (qi < QMIN) di = DW'(QMIN);
    else                di = DW'(qi);
`else
    dr = DW'(qr);
    di = DW'(qi);
`endif
  end

endmodule

// File: rtl/fft16_r2_butterfly.sv
// Radix-2 DIF butterfly: registered sum path and twiddled difference path,
// with a 3-bit twiddle index that advances once per accepted sample.
// Build option FFT_BF_SAT_EN: saturate the DW-bit results instead of wrapping.
module fft16_r2_butterfly #(
  parameter int DW = 16
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 tw_clr,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  output logic signed [DW-1:0] sr,
  output logic signed [DW-1:0] si,
  output logic signed [DW-1:0] dr,
  output logic signed [DW-1:0] di,
  output logic                 out_valid
);
  import fft16_pkg::*;

  logic        [2:0]    k, kuse;
  logic signed [DW:0]   sumr, sumi, difr, difi;
  logic signed [DW-1:0] sumr_n, sumi_n, dr_n, di_n;

  function automatic logic signed [DW-1:0] fit_sum(input logic signed [DW:0] x);
`ifdef FFT_BF_SAT_EN
    if (x[DW] != x[DW-1])
      return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return x[DW-1:0];
`else
    return DW'(x);
`endif
  endfunction

  // A sample arriving together with tw_clr is rotated by k=0
  always_comb kuse = tw_clr ? 3'd0 : k;

  // One-bit-growth sum and difference of the two operands
  always_comb begin
    sumr   = (DW+1)'(ar) + (DW+1)'(br);
    sumi   = (DW+1)'(ai) + (DW+1)'(bi);
    difr   = (DW+1)'(ar) - (DW+1)'(br);
    difi   = (DW+1)'(ai) - (DW+1)'(bi);
    sumr_n = fit_sum(sumr);
    sumi_n = fit_sum(sumi);
  end

  fft16_cmul #(.DW(DW)) u_cmul (
    .tr (difr),
    .ti (difi),
    .k  (kuse),
    .dr (dr_n),
    .di (di_n)
  );

  // Output registers and twiddle index; reset wins over everything else
  always_ff @(posedge c) begin
    if (!rst_n) begin
      sr        <= '0;
      si        <= '0;
      dr        <= '0;
      di        <= '0;
      out_valid <= 1'b0;
      k         <= 3'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sr <= sumr_n;
        si <= sumi_n;
        dr <= dr_n;
        di <= di_n;
        k  <= kuse + 3'd1;
      end else if (tw_clr) begin
        k  <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_fft16_r2_butterfly.sv
// Self-checking bench for fft16_r2_butterfly: directed steps followed by a
// randomized run, all compared against an arithmetic reference model.
// Honors FFT_BF_SAT_EN the same way the design does.
module tb_fft16_r2_butterfly;
  localparam int DW = 16;

  logic                 c = 1'b0;
  logic                 rst_n, in_valid, tw_clr;
  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [DW-1:0] sr, si, dr, di;
  logic                 out_valid;

  int checks = 0;
  int errors = 0;

  int twr [8] = '{4, 4, 2, 1, 0, -1, -2, -4};
  int twi [8] = '{0, -1, -2, -4, -4, -4, -2, -1};

  int mk = 0;
  int expSr = 0, expSi = 0, expDr = 0, expDi = 0;
  logic expValid = 1'b0;

  // Free-running clock
  always #5 c = ~c;

  fft16_r2_butterfly #(.DW(DW)) dut (
    .c         (c),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .tw_clr    (tw_clr),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .sr        (sr),
    .si        (si),
    .dr        (dr),
    .di        (di),
    .out_valid (out_valid)
  );

  function automatic int fit(input int x);
`ifdef FFT_BF_SAT_EN
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    logic signed [15:0] r;
    r = x[15:0];
    return int'(r);
`endif
  endfunction

  task automatic applyStimulus(input logic rn, input logic v, input logic clr,
                               input int xar, input int xai, input int xbr, input int xbi);
    int a_r, a_i, b_r, b_i, kk, tr, ti;
    rst_n    = rn;
    in_valid = v;
    tw_clr   = clr;
    ar = DW'(xar);
    ai = DW'(xai);
    br = DW'(xbr);
    bi = DW'(xbi);
    a_r = int'(ar);
    a_i = int'(ai);
    b_r = int'(br);
    b_i = int'(bi);
    @(posedge c);
    #1;
    if (!rn) begin
      expSr = 0; expSi = 0; expDr = 0; expDi = 0;
      expValid = 1'b0;
      mk = 0;
    end else begin
      expValid = v;
      if (v) begin
        kk = clr ? 0 : mk;
        tr = a_r - b_r;
        ti = a_i - b_i;
        expSr = fit(a_r + b_r);
        expSi = fit(a_i + b_i);
        expDr = fit((twr[kk] * tr - twi[kk] * ti) / 4);
        expDi = fit((twr[kk] * ti + twi[kk] * tr) / 4);
        mk = (kk + 1) % 8;
      end else if (clr) begin
        mk = 0;
      end
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (out_valid === expValid) else begin
      errors++;
      $error("[TB] FAIL %s.valid: observed %b expected %b", tag, out_valid, expValid);
    end
    checkValue({tag, ".sr"}, int'(sr), expSr);
    checkValue({tag, ".si"}, int'(si), expSi);
    checkValue({tag, ".dr"}, int'(dr), expDr);
    checkValue({tag, ".di"}, int'(di), expDi);
  endtask

  int exp6r [9] = '{4, 4, 2, 1, 0, -1, -2, -4, 4};
  int exp6i [9] = '{0, -1, -2, -4, -4, -4, -2, -1, 0};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; tw_clr = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;

    // Reset held two cycles with samples presented
    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 500, -7, 33, 91);
    applyStimulus(1'b0, 1'b1, 1'b0, 1234, 5, -99, 8);
    checkOutput("reset");
    checkValue("reset.valid0", int'(out_valid), 0);

    // k=0 straight after reset
    applyStimulus(1'b1, 1'b1, 1'b0, 100, 0, 20, 0);
    checkOutput("k0");
    checkValue("k0.sr", int'(sr), 120);
    checkValue("k0.dr", int'(dr), 80);
    checkValue("k0.di", int'(di), 0);

    // Advance to k=3
    applyStimulus(1'b1, 1'b1, 1'b0, 11, -3, 2, 7);
    checkOutput("k1");
    applyStimulus(1'b1, 1'b1, 1'b0, -50, 60, 25, -5);
    checkOutput("k2");
    applyStimulus(1'b1, 1'b1, 1'b0, 40, 8, 0, 0);
    checkOutput("k3");
    checkValue("k3.dr", int'(dr), 18);
    checkValue("k3.di", int'(di), -38);

    // Truncation toward zero at k=2
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    checkOutput("clr_idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 9, 9, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 9, 9, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3, 0, 0, 0);
    checkOutput("trunc");
    checkValue("trunc.dr", int'(dr), 1);
    checkValue("trunc.di", int'(di), -1);

    // Sum overflow
    applyStimulus(1'b1, 1'b1, 1'b1, 32767, 0, 1, 0);
    checkOutput("ovf");
`ifdef FFT_BF_SAT_EN
    checkValue("ovf.sr", int'(sr), 32767);
`else
    checkValue("ovf.sr", int'(sr), -32768);
`endif

    // Index wrap with idle cycles interleaved
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 4, 0, 0, 0);
      checkOutput("wrap");
      checkValue("wrap.dr", int'(dr), exp6r[i]);
      checkValue("wrap.di", int'(di), exp6i[i]);
      if (i % 2 == 1) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 77, 77, 77, 77);
        checkOutput("wrap.idle");
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4, 0, 0, 0);
    checkOutput("midclr");
    checkValue("midclr.dr", int'(dr), 4);
    checkValue("midclr.di", int'(di), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4, 0, 0, 0);
    checkValue("midclr.next.di", int'(di), -1);

    // Randomized traffic with occasional reset and clear
    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      logic rn, v, clr;
      int xar, xai, xbr, xbi;
      rn  = ($urandom_range(0, 24) != 0);
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      xar = int'($urandom_range(0, 65535)) - 32768;
      xai = int'($urandom_range(0, 65535)) - 32768;
      xbr = int'($urandom_range(0, 65535)) - 32768;
      xbi = int'($urandom_range(0, 65535)) - 32768;
      applyStimulus(rn, v, clr, xar, xai, xbr, xbi);
      checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft16_r2_butterfly.md
# fft16_r2_butterfly

Radix-2 decimation-in-frequency butterfly for the 16-point pipelined FFT datapath. It takes two complex 16-bit samples, outputs their sum, and outputs their difference rotated by a coarse twiddle factor selected by an internal 3-bit sample counter. It sits between the first-stage delay line and the downstream sub-FFT processors.

## Interface
- Parameters:
- `DW`, 16, width of each real/imag component (signed two's complement).
- Ports:
- `c`  input  1  clock; all state updates on its rising edge.
- `rst_n`  input  1  reset; synchronous and active-low.
- `in_valid`  input  1  `a`/`b` carry a sample this cycle.
- `tw_clr`  input  1  restart twiddle index at 0.
- `ar`, `ai`  input  DW  operand A (delayed sample), real and imag.
- `br`, `bi`  input  DW  operand B (current sample), real and imag.
- `sr`, `si`  output  DW  sum path, real and imag.
- `dr`, `di`  output  DW  twiddled difference path, real and imag.
- `out_valid`  output  1  outputs hold a new result.

## Operation
- Twiddle table, scaled by 4 (4 = 1.0), index k = 0..7:
  - `wr` = {4, 4, 2, 1, 0, -1, -2, -4}
  - `wi` = {0, -1, -2, -4, -4, -4, -2, -1}
- On an accepted sample (`in_valid`=1):
  - `s = a + b`, per component.
  - `t = a - b`, per component.
  - `dr = (wr[k]*t.r - wi[k]*t.i) / 4`
  - `di = (wr[k]*t.i + wi[k]*t.r) / 4`
- Arithmetic widths:
  - Sums and differences are computed at DW+1 bits.
  - Products and sums of products are computed at full width.
  - Division by 4 is signed and truncates toward zero. It is a true division, not an arithmetic shift.
  - The final result is reduced to DW bits by dropping high bits (wrap), unless the saturation option below is enabled.
- Twiddle index k:
  - 3-bit, increments by 1 after each accepted sample and wraps 7→0.
  - Holds while `in_valid`=0.
- `tw_clr`:
  - The sample accepted in the same cycle as `tw_clr` uses k=0, and the next index is 1.
  - Without a concurrent sample, the next index is 0.

## Timing
- Registered outputs, latency 1: a sample accepted at edge N appears on the outputs, with `out_valid`=1, after edge N.
- With `in_valid`=0, `out_valid` drops to 0 after the next edge and the data outputs hold their last values.
- Full throughput: one sample per cycle, no back-pressure.
- Reset (`rst_n`=0 at an edge):
  - All data outputs become 0, `out_valid` becomes 0, k becomes 0.
  - Reset has priority over `in_valid` and `tw_clr`.
  - A sample presented during reset is discarded.
- `tw_clr` and `in_valid` together: the sample is processed with k=0, as described in Operation.

## Configuration
- `FFT_BF_SAT_EN`:
  - Defined: each DW-bit result (sum, dr, di) saturates to [-2^(DW-1), 2^(DW-1)-1].
  - Undefined: results wrap (two's-complement truncation).
- Latency is unaffected either way.

## Structure
- Package `fft16_pkg` holds:
  - `DW`.
  - Complex sample typedef (re/im signed DW).
  - The `wr`/`wi` twiddle constant arrays.
  - Twiddle scale constant (4).
- One sub-module: `fft16_cmul`, the combinational complex multiply by a table twiddle, with /4 scaling and the optional saturation. The top level holds the adders, the index counter and the output registers.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles while `in_valid`=1 → all outputs 0, `out_valid`=0, and the first post-reset sample uses k=0.
2. k=0: a=(100,0), b=(20,0) → one cycle later s=(120,0), d=(80,0), `out_valid`=1.
3. k=3: after 3 accepted samples, a=(40,8), b=(0,0) → s=(40,8), d=(18,-38).
4. Truncation at k=2: a=(3,0), b=(0,0) → d=(1,-1). 6/4 gives 1 and -6/4 gives -1, both toward zero.
5. Overflow: a=(32767,0), b=(1,0) → s.r=-32768 without `FFT_BF_SAT_EN`, 32767 with it.
6. Index wrap and hold: 9 accepted samples with a=(4,0), b=(0,0), including idle cycles interleaved → d sequence (4,0),(4,-1),(2,-2),(1,-4),(0,-4),(-1,-4),(-2,-2),(-4,-1),(4,0). Asserting `tw_clr` mid-sequence makes the next result (4,0).
